seg7_scan_driver: RTL

Time-multiplexed driver for an 8-digit common-anode seven-segment display. It consumes the 7-bit digit codes produced by the digital-clock core (seconds, minutes, hours, AM/PM, one spare) and scans them onto shared active-low segment and anode lines. Each slot starts with an anti-ghosting blank window. Per-digit blinking is supported for time-set mode. It sits between the clock core and the board pins.

---
 rtl/dig_disp_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dig_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dig_disp_pkg
//  Purpose  : Shared constants for the seven-segment display path: digit
//             count, digit-code bit positions and the hex segment table.
//  Revision : 1.0  initial release
// ============================================================================
package dig_disp_pkg;

    localparam int NUM_DIGITS = 8;

    // Digit-code bit positions (bits [3:0] carry the hex value, bit 4 unused)
    localparam int DIG_DP    = 5;
    localparam int DIG_BLANK = 6;

    // All segments off (active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segment patterns, seg[0]=a .. seg[6]=g; entry 0 is rightmost
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage : dig_disp_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational full-hex to active-low seven-segment decoder.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import dig_disp_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[val_i];

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed scan driver for an 8-digit common-anode
//             seven-segment display with anti-ghost blanking and per-digit
//             blinking.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import dig_disp_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000,
    parameter int BLINK_FRAMES = 62
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] d0,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [7:0] blink_mask,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] scan_idx,
    output logic       frame_done
);

    localparam int CNT_W   = $clog2(DIGIT_CYCLES);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   C_CNT_LAST    = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_CNT_PRELAST = CNT_W'(DIGIT_CYCLES - 2);
    localparam logic [CNT_W-1:0]   C_BLANK       = CNT_W'(BLANK_CYCLES);
    localparam logic [FRAME_W-1:0] C_FRAME_LAST  = FRAME_W'(BLINK_FRAMES - 1);

    // Scan state
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [2:0]         idx_q,         idx_d;
    logic [6:0]         cur_q,         cur_d;
    logic [FRAME_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Registered outputs
    logic [7:0] an_q,   an_d;
    logic [6:0] seg_q,  seg_d;
    logic       dp_q,   dp_d;
    logic       fd_q,   fd_d;

    logic [NUM_DIGITS-1:0][6:0] w_digits;
    logic [6:0] w_digit_sel;
    logic [6:0] w_cur_eff;
    logic [6:0] w_seg_dec;
    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_visible;
    logic       w_dark;
    logic       w_unused_bit4;

    assign w_digits    = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign w_digit_sel = w_digits[idx_q];
    assign w_slot_end  = (cnt_q == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (idx_q == 3'd7);

    // On the snapshot cycle cur_q still holds the previous slot's digit, so the
    // output path looks through to the value being captured. This keeps the
    // visible window exact when the blank window is zero cycles long.
    assign w_cur_eff     = (cnt_q == '0) ? w_digit_sel : cur_q;
    assign w_unused_bit4 = w_cur_eff[4];

    seg7_decode u_decode (
        .val_i (w_cur_eff[3:0]),
        .seg_o (w_seg_dec)
    );

    // Slot counter, digit index, snapshot and blink state advance
    always_comb begin
        cnt_d         = w_slot_end ? '0 : cnt_q + 1'b1;
        idx_d         = w_slot_end ? idx_q + 3'd1 : idx_q;
        cur_d         = (cnt_q == '0) ? w_digit_sel : cur_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (w_frame_end) begin
            if (frame_cnt_q == C_FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Next-output function; the last slot cycle is dark so the registered
    // outputs show exactly BLANK_CYCLES+1 dark cycles per slot and slots never overlap
    always_comb begin
        w_visible = ~blink_phase_q | ~blink_mask[idx_q];
        w_dark    = (cnt_q < C_BLANK) | w_slot_end | w_cur_eff[DIG_BLANK] | ~w_visible;
        an_d      = 8'hFF;
        seg_d     = SEG_OFF;
        dp_d      = 1'b1;
        if (!w_dark) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = w_seg_dec;
            dp_d  = ~w_cur_eff[DIG_DP];
        end
        // Registered one cycle early so the pulse lands on the last cycle of slot 7
        fd_d = (idx_q == 3'd7) && (cnt_q == C_CNT_PRELAST);
    end

    // Scan state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            cur_q         <= 7'h40;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            cur_q         <= cur_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Output registers; dark immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;
    assign scan_idx   = idx_q;

endmodule : seg7_scan_driver
`default_nettype wire
